// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the CPU run controller: command ops, FSM states, stop causes,
// and the stop-cause priority resolver.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    OpRun   = 2'd0,
    OpStep  = 2'd1,
    OpPause = 2'd2,
    OpClear = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StStep   = 2'd2,
    StHalted = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    CauseHalt     = 2'd0,
    CauseBp       = 2'd1,
    CauseStepDone = 2'd2,
    CausePause    = 2'd3
  } stop_cause_e;

  // HALT beats breakpoint beats step exhaustion; PAUSE only when no stop event fired.
  function automatic stop_cause_e stop_cause_sel(input logic halt, input logic bp,
                                                 input logic step_done);
    if (halt) begin
      return CauseHalt;
    end else if (bp) begin
      return CauseBp;
    end else if (step_done) begin
      return CauseStepDone;
    end
    return CausePause;
  endfunction

endpackage

// File: rtl/run_ctr.sv
// Wrapping up-counter with synchronous clear (dominant over increment).
module run_ctr #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: gates the core's global_en from host RUN/STEP/PAUSE/CLEAR commands and
// stops on HALT, PC breakpoint or step exhaustion, observed on the core's commit stream.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             bp_en,
  input  logic [31:0]      bp_pc,
  input  logic             commit,
  input  logic [31:0]      commit_pc,
  input  logic             commit_halt,
  output logic             global_en,
  output logic [1:0]       run_state,
  output logic             stop_valid,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  run_state_e       state_q, state_d;
  stop_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] step_left_q, step_left_d;
  logic             en_q;
  logic             stop_valid_q, stop_valid_d;
  logic             clr_cnt;

  cmd_op_e op;
  logic    running, cq, halt_hit, bp_hit, step_hit, stop_now;

  assign op      = cmd_op_e'(cmd_op);
  assign running = (state_q == StRun) || (state_q == StStep);
  // The core holds commit high while disabled; only commits following an enabled cycle count.
  assign cq       = commit & en_q;
  assign halt_hit = running & cq & commit_halt;
  assign bp_hit   = running & cq & bp_en & (commit_pc == bp_pc);
  assign step_hit = (state_q == StStep) & cq & (step_left_q == CNT_W'(1));
  assign stop_now = halt_hit | bp_hit | step_hit;

  // Combinational so the instruction after a stopping commit never executes.
  assign global_en = running & ~stop_now;

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    step_left_d  = step_left_q;
    stop_valid_d = 1'b0;
    clr_cnt      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          unique case (op)
            OpRun:  state_d = StRun;
            OpStep: begin
              state_d     = StStep;
              step_left_d = (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
            end
            OpClear: begin
              clr_cnt = 1'b1;
              cause_d = CauseHalt;
            end
            OpPause: ;
          endcase
        end
      end
      StRun, StStep: begin
        if ((state_q == StStep) && cq) begin
          step_left_d = step_left_q - CNT_W'(1);
        end
        if (stop_now) begin
          stop_valid_d = 1'b1;
          cause_d      = stop_cause_sel(halt_hit, bp_hit, step_hit);
          state_d      = halt_hit ? StHalted : StIdle;
        end else if (cmd_valid && (op == OpPause)) begin
          stop_valid_d = 1'b1;
          cause_d      = CausePause;
          state_d      = StIdle;
        end
      end
      StHalted: begin
        if (cmd_valid && (op == OpClear)) begin
          clr_cnt = 1'b1;
          cause_d = CauseHalt;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cause_q      <= CauseHalt;
      step_left_q  <= '0;
      en_q         <= 1'b0;
      stop_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      step_left_q  <= step_left_d;
      en_q         <= global_en;
      stop_valid_q <= stop_valid_d;
    end
  end

  assign run_state  = state_q;
  assign stop_cause = cause_q;
  assign stop_valid = stop_valid_q;

  run_ctr #(
    .CNT_W(CNT_W)
  ) u_cycle_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (global_en),
    .cnt  (cycle_cnt)
  );

  run_ctr #(
    .CNT_W(CNT_W)
  ) u_inst_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (running & cq),
    .cnt  (inst_cnt)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a single-cycle core model that holds commit while disabled.
module tb_cpu_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int unsigned CNT_W = 32;
  localparam logic [31:0] PC0   = 32'h1c00_0000;
  localparam int          NV    = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'd0;
  logic [CNT_W-1:0] cmd_arg = '0;
  logic             bp_en = 1'b0;
  logic [31:0]      bp_pc = '0;
  logic             commit;
  logic [31:0]      commit_pc;
  logic             commit_halt;
  logic             global_en;
  logic [1:0]       run_state;
  logic             stop_valid;
  logic [1:0]       stop_cause;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;

  logic [31:0] pc;
  logic [31:0] halt_pc = '0;

  int tests = 0;
  int failed = 0;

  cpu_run_ctrl #(
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .bp_en      (bp_en),
    .bp_pc      (bp_pc),
    .commit     (commit),
    .commit_pc  (commit_pc),
    .commit_halt(commit_halt),
    .global_en  (global_en),
    .run_state  (run_state),
    .stop_valid (stop_valid),
    .stop_cause (stop_cause),
    .cycle_cnt  (cycle_cnt),
    .inst_cnt   (inst_cnt)
  );

  always #5 clk = ~clk;

  // Core model: executes pc when enabled, registers the commit, holds it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= PC0;
      commit      <= 1'b0;
      commit_pc   <= '0;
      commit_halt <= 1'b0;
    end else if (global_en) begin
      commit      <= 1'b1;
      commit_pc   <= pc;
      commit_halt <= (pc == halt_pc);
      pc          <= pc + 32'd4;
    end
  end

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [31:0] arg;
    logic        bpe;
    logic [31:0] bpp;
    logic [31:0] hpc;
    int          cycles;
    logic        exp_en;
    logic [1:0]  exp_state;
    logic [1:0]  exp_cause;
    logic [31:0] exp_inst;
    logic [31:0] exp_cyc;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic valid, input logic [1:0] op, input logic [31:0] arg,
                              input logic bpe, input logic [31:0] bpp, input logic [31:0] hpc,
                              input int cycles, input logic en, input logic [1:0] st,
                              input logic [1:0] cause, input logic [31:0] inst,
                              input logic [31:0] cyc, input int pulses);
    vec_t v;
    v.valid      = valid;
    v.op         = op;
    v.arg        = arg;
    v.bpe        = bpe;
    v.bpp        = bpp;
    v.hpc        = hpc;
    v.cycles     = cycles;
    v.exp_en     = en;
    v.exp_state  = st;
    v.exp_cause  = cause;
    v.exp_inst   = inst;
    v.exp_cyc    = cyc;
    v.exp_pulses = pulses;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    vec_t v;

    //        vld op       arg  bpe bp_pc         halt_pc       cyc en st  cause inst cyc pulses
    vecs[0] = mk(0, OpRun,   0, 0, 32'h0,        32'h0,        5,  0, 0, 0,   0,   0,  0);
    vecs[1] = mk(1, OpStep,  3, 0, 32'h0,        32'h0,        8,  0, 0, 2,   3,   3,  1);
    vecs[2] = mk(1, OpRun,   0, 1, 32'h1c000010, 32'h0,        10, 0, 0, 1,   5,   5,  1);
    vecs[3] = mk(1, OpRun,   0, 1, 32'h1c000010, 32'h0,        3,  1, 1, 1,   6,   7,  0);
    vecs[4] = mk(1, OpPause, 0, 1, 32'h1c000010, 32'h0,        4,  0, 0, 3,   7,   8,  1);
    vecs[5] = mk(1, OpRun,   0, 1, 32'h1c000020, 32'h1c000020, 6,  0, 3, 0,   8,   9,  1);
    vecs[6] = mk(1, OpRun,   0, 1, 32'h1c000020, 32'h1c000020, 3,  0, 3, 0,   8,   9,  0);
    vecs[7] = mk(1, OpStep,  2, 1, 32'h1c000020, 32'h1c000020, 3,  0, 3, 0,   8,   9,  0);
    vecs[8] = mk(1, OpClear, 0, 1, 32'h1c000020, 32'h1c000020, 2,  0, 0, 0,   0,   0,  0);
    vecs[9] = mk(1, OpStep,  0, 0, 32'h0,        32'h0,        5,  0, 0, 2,   1,   1,  1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset state", {30'd0, run_state}, 32'd0);
    check("reset en", {31'd0, global_en}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      v         = vecs[i];
      bp_en     = v.bpe;
      bp_pc     = v.bpp;
      halt_pc   = v.hpc;
      cmd_valid = v.valid;
      cmd_op    = v.op;
      cmd_arg   = v.arg;
      pulses    = 0;
      for (int c = 0; c < v.cycles; c++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (stop_valid) pulses++;
      end
      check($sformatf("v%0d global_en", i), {31'd0, global_en}, {31'd0, v.exp_en});
      check($sformatf("v%0d run_state", i), {30'd0, run_state}, {30'd0, v.exp_state});
      check($sformatf("v%0d stop_cause", i), {30'd0, stop_cause}, {30'd0, v.exp_cause});
      check($sformatf("v%0d inst_cnt", i), inst_cnt, v.exp_inst);
      check($sformatf("v%0d cycle_cnt", i), cycle_cnt, v.exp_cyc);
      check($sformatf("v%0d stop pulses", i), pulses, v.exp_pulses);
    end

    // PAUSE in the same cycle as a breakpoint commit: breakpoint cause wins.
    bp_en     = 1'b1;
    bp_pc     = 32'h1c00_002c;
    cmd_valid = 1'b1;
    cmd_op    = OpRun;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp+pause en rises", {31'd0, global_en}, 32'd1);
    check("bp+pause state run", {30'd0, run_state}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("bp+pause en drop", {31'd0, global_en}, 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = OpPause;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp+pause stop_valid", {31'd0, stop_valid}, 32'd1);
    check("bp+pause cause", {30'd0, stop_cause}, 32'd1);
    check("bp+pause state", {30'd0, run_state}, 32'd0);
    check("bp+pause inst", inst_cnt, 32'd3);
    check("bp+pause cycles", cycle_cnt, 32'd3);
    @(negedge clk);
    check("bp+pause pulse end", {31'd0, stop_valid}, 32'd0);

    // Asynchronous reset mid-run.
    bp_en     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OpRun;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-run en", {31'd0, global_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst en", {31'd0, global_en}, 32'd0);
    check("async rst state", {30'd0, run_state}, 32'd0);
    check("async rst cause", {30'd0, stop_cause}, 32'd0);
    check("async rst cycles", cycle_cnt, 32'd0);
    check("async rst inst", inst_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst en", {31'd0, global_en}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sequences the single-cycle CPU core by driving its `global_en` input. It accepts run, step, pause and clear commands from the simulation or debug host. It watches the core's registered commit stream to stop on HALT, on a PC breakpoint, or when a step count is exhausted, and it keeps cycle and instruction counters. It sits between the debug host and the CPU top: its `global_en` goes to the core, and the core's `commit`, `commit_pc` and `commit_halt` come back to it.

## Interface
- `CNT_W`, default 32: width of the step argument and both counters.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command strobe, held for one cycle.
- `cmd_op` in 2: command encoding; 0 = RUN, 1 = STEP, 2 = PAUSE, 3 = CLEAR.
- `cmd_arg` in CNT_W: instruction count for STEP.
- `bp_en` in 1: breakpoint enable.
- `bp_pc` in 32: breakpoint PC.
- `commit` in 1: core commit flag (registered in the core).
- `commit_pc` in 32: PC of the committed instruction.
- `commit_halt` in 1: the committed instruction is HALT.
- `global_en` out 1: core enable.
- `run_state` out 2: current FSM state.
- `stop_valid` out 1: one-cycle pulse when execution stops.
- `stop_cause` out 2: cause of the last stop; held until the next stop or CLEAR.
- `cycle_cnt` out CNT_W: number of cycles with `global_en` = 1.
- `inst_cnt` out CNT_W: number of qualified commits.

## Operation
- **Commit qualification.** The core holds `commit` = 1 while disabled, so a held value must not count as a new commit.
  - `en_d` is `global_en` registered, reset value 0.
  - `cq = commit & en_d`. Only `cq` is counted or checked.
- **States:** IDLE = 0, RUN = 1, STEP = 2, HALTED = 3.
- **IDLE:**
  - RUN → RUN.
  - STEP → STEP, loading `step_left = (cmd_arg == 0) ? 1 : cmd_arg`.
  - CLEAR zeroes both counters and `stop_cause`.
  - PAUSE is ignored.
- **RUN / STEP:**
  - On `cq`, `inst_cnt` increments. In STEP, `step_left` also decrements.
  - A stop event is `cq` with any of:
    - `commit_halt`, → HALTED.
    - `bp_en & (commit_pc == bp_pc)`, → IDLE.
    - in STEP only, `step_left == 1`, → IDLE.
  - PAUSE with no stop event → IDLE.
  - RUN, STEP and CLEAR are ignored.
- **HALTED:** only CLEAR is accepted; it zeroes the counters and cause and goes to IDLE. The core itself is not reset.
- **Cause priority:** HALT = 0 > BP = 1 > STEP_DONE = 2 > PAUSE = 3.
  - A stop event in the same cycle as PAUSE drops the PAUSE.
- **Enable:** `global_en = (run_state ∈ {RUN, STEP}) & ~stop_now`. It is combinational, so the instruction after a stopping commit never executes.
- **Counters:** both wrap modulo 2^CNT_W. There is no saturation.
- **Resume:** RUN issued after a breakpoint stop does not re-trigger on the stale commit, because `en_d` = 0 in the first enabled cycle.

## Timing
- Reset values: `run_state` = IDLE, `global_en` = 0, `stop_valid` = 0, `stop_cause` = 0, `cycle_cnt` = 0, `inst_cnt` = 0, `step_left` = 0, `en_d` = 0.
- A command is sampled at edge t. `run_state` changes and `global_en` rises in cycle t+1.
- The first qualified commit can occur in cycle t+2.
- A stop event in cycle s:
  - `global_en` = 0 in cycle s.
  - `run_state` and `stop_cause` update at edge s.
  - `stop_valid` = 1 during cycle s+1 only.
- STEP N executes and commits exactly N instructions.
- Reset asserted mid-run: all state clears asynchronously and `global_en` drops immediately.

## Structure
- Package `run_ctrl_pkg` holds:
  - the `cmd_op` encodings;
  - the state encodings;
  - the `stop_cause` encodings;
  - the cause-priority function.
- Sub-module `run_ctr` is a CNT_W counter with clear, increment and async active-low reset. It is instantiated twice, for `cycle_cnt` and `inst_cnt`.
- The step down-counter stays inline in the FSM.

## Test plan
- **Reset and idle:** reset, then idle 5 cycles → `global_en` = 0, both counters 0, `run_state` = 0.
- **STEP 3:** STEP with `cmd_arg` = 3, commits on every enabled cycle → exactly 3 qualified commits, `inst_cnt` = 3, `cycle_cnt` = 3, `stop_cause` = 2, a single `stop_valid` pulse, `run_state` = IDLE.
- **Breakpoint then resume:** `bp_pc` = 0x1c00_0010 with `bp_en` = 1, then RUN → stop on the commit with that PC, `stop_cause` = 1. A following RUN, with the commit still showing 0x1c00_0010, does not re-stop; execution continues.
- **HALT beats BP:** a commit with `commit_halt` = 1 and `commit_pc == bp_pc` → `stop_cause` = 0 and `run_state` = HALTED. Later RUN and STEP are ignored; CLEAR → IDLE with counters 0.
- **PAUSE vs. stop event:** PAUSE in RUN with no commit event → IDLE, cause 3. PAUSE in the same cycle as a breakpoint commit → cause 1.
- **Reset mid-run and STEP 0:** reset mid-run → `global_en` drops with no clock edge and the counters clear. STEP with `cmd_arg` = 0 → exactly 1 instruction.
